// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-input multiplexer family.
package mux_pkg;

  localparam int MUX_DEFAULT_VALUE = 0;

  // Number of lanes a select of the given width can address.
  function automatic int max_inputs(input int sel_width);
    return 1 << sel_width;
  endfunction

endpackage

// File: rtl/nbit_onehot_decode.sv
// One-hot decode of a lane select; flags selects that address no populated lane.
import mux_pkg::*;

module nbit_onehot_decode #(
  parameter int SELECT_WIDTH = 1,
  parameter int NUM_INPUTS   = max_inputs(SELECT_WIDTH)
) (
  input  logic [SELECT_WIDTH-1:0] i_select,
  output logic [NUM_INPUTS-1:0]   o_onehot,
  output logic                    o_sel_err
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > max_inputs(SELECT_WIDTH)) begin : g_bad_params
    $fatal(1, "nbit_onehot_decode: NUM_INPUTS out of legal range");
  end

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_dec
    assign o_onehot[k] = (i_select == SELECT_WIDTH'(k));
  end

  // No populated lane matched, so the select is past the last lane.
  assign o_sel_err = ~|o_onehot;

endmodule

// File: rtl/nbit_mux_core.sv
// Parameterized N-input multiplexer with a registered copy of the output and select error.
import mux_pkg::*;

module nbit_mux_core #(
  parameter int                    SELECT_WIDTH  = 1,
  parameter int                    NUM_INPUTS    = max_inputs(SELECT_WIDTH),
  parameter int                    DATA_WIDTH    = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = DATA_WIDTH'(MUX_DEFAULT_VALUE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in,
  input  logic [SELECT_WIDTH-1:0]          select,
  input  logic                             en,
  output logic [DATA_WIDTH-1:0]            out,
  output logic [DATA_WIDTH-1:0]            out_q,
  output logic                             sel_err,
  output logic                             sel_err_q
);

  logic [NUM_INPUTS-1:0] w_onehot;
  logic                  w_sel_err;
  logic [DATA_WIDTH-1:0] w_and_or;
  logic [DATA_WIDTH-1:0] r_out_q;
  logic                  r_sel_err_q;

  nbit_onehot_decode #(
    .SELECT_WIDTH (SELECT_WIDTH),
    .NUM_INPUTS   (NUM_INPUTS)
  ) u_decode (
    .i_select  (select),
    .o_onehot  (w_onehot),
    .o_sel_err (w_sel_err)
  );

  // AND each lane with its decode bit and OR the lanes together per bit.
  always_comb begin
    w_and_or = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_and_or = w_and_or | (in[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_onehot[k]}});
    end
  end

  assign out     = w_sel_err ? DEFAULT_VALUE : w_and_or;
  assign sel_err = w_sel_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q     <= '0;
      r_sel_err_q <= 1'b0;
    end else if (en) begin
      r_out_q     <= out;
      r_sel_err_q <= w_sel_err;
    end
  end

  assign out_q     = r_out_q;
  assign sel_err_q = r_sel_err_q;

endmodule

// File: tb/tb_nbit_mux_core.sv
// Self-checking bench for nbit_mux_core: vector table, directed sequences, exhaustive 4x1 slice, random run.
module tb_nbit_mux_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Config A: 4 lanes x 32 bits, default 0
  logic [31:0]  lane_a [4];
  logic [127:0] in_a;
  logic [1:0]   sel_a = 2'd0;
  logic         en_a = 1'b0;
  logic [31:0]  out_a, out_q_a;
  logic         err_a, err_q_a;
  assign in_a = {lane_a[3], lane_a[2], lane_a[1], lane_a[0]};

  // Config B: 3 lanes x 32 bits, default FFFFFFFF
  logic [31:0] lane_b [3];
  logic [95:0] in_b;
  logic [1:0]  sel_b = 2'd0;
  logic        en_b = 1'b0;
  logic [31:0] out_b, out_q_b;
  logic        err_b, err_q_b;
  assign in_b = {lane_b[2], lane_b[1], lane_b[0]};

  // Config C: mux_4x1 bit slice
  logic [3:0] in_c = 4'd0;
  logic [1:0] sel_c = 2'd0;
  logic       en_c = 1'b0;
  logic       out_c, out_q_c, err_c, err_q_c;

  nbit_mux_core #(.SELECT_WIDTH(2), .NUM_INPUTS(4), .DATA_WIDTH(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .select(sel_a), .en(en_a),
    .out(out_a), .out_q(out_q_a), .sel_err(err_a), .sel_err_q(err_q_a));

  nbit_mux_core #(.SELECT_WIDTH(2), .NUM_INPUTS(3), .DATA_WIDTH(32),
                  .DEFAULT_VALUE(32'hFFFF_FFFF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .select(sel_b), .en(en_b),
    .out(out_b), .out_q(out_q_b), .sel_err(err_b), .sel_err_q(err_q_b));

  nbit_mux_core #(.SELECT_WIDTH(2), .NUM_INPUTS(4), .DATA_WIDTH(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in(in_c), .select(sel_c), .en(en_c),
    .out(out_c), .out_q(out_q_c), .sel_err(err_c), .sel_err_q(err_q_c));

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q [$];   // {sel_err_q, out_q} expected after each random-phase edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lane[sel] when the lane exists, otherwise the default value.
  function automatic logic [31:0] ref_b(input logic [1:0] sel, input logic [31:0] l0,
                                        input logic [31:0] l1, input logic [31:0] l2);
    logic [31:0] lanes [3];
    lanes[0] = l0; lanes[1] = l1; lanes[2] = l2;
    if (int'(sel) < 3) return lanes[sel];
    return 32'hFFFF_FFFF;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    logic [31:0] lane2;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic [32:0] exp;
    logic [31:0] m_out_q;
    logic        m_err_q;
    logic [31:0] m_out;
    logic [3:0]  pat;

    lane_a[0] = 32'hAAAA_AAAA; lane_a[1] = 32'hBBBB_BBBB;
    lane_a[2] = 32'hCCCC_CCCC; lane_a[3] = 32'hDDDD_DDDD;
    lane_b[0] = 32'h0; lane_b[1] = 32'h0; lane_b[2] = 32'h0;

    vecs[0] = '{2'd0, 32'hCCCC_CCCC, 32'hAAAA_AAAA, 1'b0};
    vecs[1] = '{2'd1, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 1'b0};
    vecs[2] = '{2'd2, 32'hCCCC_CCCC, 32'hCCCC_CCCC, 1'b0};
    vecs[3] = '{2'd3, 32'hCCCC_CCCC, 32'hDDDD_DDDD, 1'b0};
    vecs[4] = '{2'd1, 32'h1234_5678, 32'hBBBB_BBBB, 1'b0};
    vecs[5] = '{2'd2, 32'h1234_5678, 32'h1234_5678, 1'b0};

    // Reset state, with en high to show reset wins
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    tick(); tick();
    check("rst_out_q_a", out_q_a, 32'h0);
    check("rst_err_q_a", {31'b0, err_q_a}, 32'h0);
    check("rst_out_q_b", out_q_b, 32'h0);
    check("rst_out_q_c", {31'b0, out_q_c}, 32'h0);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    rst_n = 1'b1;

    // Select sweep and lane-change isolation
    for (int i = 0; i < 6; i++) begin
      sel_a = vecs[i].sel;
      lane_a[2] = vecs[i].lane2;
      #1;
      check($sformatf("vec%0d_out", i), out_a, vecs[i].exp_out);
      check($sformatf("vec%0d_err", i), {31'b0, err_a}, {31'b0, vecs[i].exp_err});
    end

    // Out-of-range select on the 3-lane config
    sel_b = 2'd3; en_b = 1'b1;
    #1;
    check("b_default_out", out_b, 32'hFFFF_FFFF);
    check("b_sel_err", {31'b0, err_b}, 32'h1);
    tick();
    check("b_default_out_q", out_q_b, 32'hFFFF_FFFF);
    check("b_sel_err_q", {31'b0, err_q_b}, 32'h1);
    sel_b = 2'd1;
    #1;
    check("b_in_range_err", {31'b0, err_b}, 32'h0);
    en_b = 1'b0;

    // Registered path: load, then hold with en low
    sel_a = 2'd3; lane_a[3] = 32'h8765_4321; en_a = 1'b1;
    tick();
    check("a_load_out_q", out_q_a, 32'h8765_4321);
    en_a = 1'b0; lane_a[3] = 32'h1111_1111;
    #1;
    check("a_hold_out", out_a, 32'h1111_1111);
    tick();
    check("a_hold_out_q", out_q_a, 32'h8765_4321);

    // Reset mid-operation with en high
    en_a = 1'b1; rst_n = 1'b0;
    tick();
    check("a_midrst_out_q", out_q_a, 32'h0);
    check("a_midrst_err_q", {31'b0, err_q_a}, 32'h0);
    check("a_midrst_out", out_a, 32'h1111_1111);
    rst_n = 1'b1;
    tick();
    check("a_reload_out_q", out_q_a, 32'h1111_1111);
    en_a = 1'b0;

    // Exhaustive 4x1 bit slice
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 4; s++) begin
        pat = 4'(p);
        in_c = pat; sel_c = 2'(s);
        #1;
        check($sformatf("c_p%0d_s%0d", p, s), {31'b0, out_c}, {31'b0, pat[s]});
      end
    end
    check("c_err_never", {31'b0, err_c}, 32'h0);

    // Random run on the 3-lane config against the reference model
    m_out_q = 32'h0; m_err_q = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      lane_b[0] = $urandom; lane_b[1] = $urandom; lane_b[2] = $urandom;
      sel_b = 2'($urandom_range(0, 3));
      en_b  = 1'($urandom_range(0, 1));
      rst_n = (cyc == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
      #1;
      m_out = ref_b(sel_b, lane_b[0], lane_b[1], lane_b[2]);
      check("rnd_out", out_b, m_out);
      check("rnd_err", {31'b0, err_b}, {31'b0, (int'(sel_b) >= 3)});
      if (!rst_n) begin
        m_out_q = 32'h0; m_err_q = 1'b0;
      end else if (en_b) begin
        m_out_q = m_out; m_err_q = (int'(sel_b) >= 3);
      end
      exp_q.push_back({m_err_q, m_out_q});
      tick();
      exp = exp_q.pop_front();
      check("rnd_out_q", out_q_b, exp[31:0]);
      check("rnd_err_q", {31'b0, err_q_b}, {31'b0, exp[32]});
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nbit_mux_core.md
Name: nbit_mux_core

Overview:
Parameterized N-input, DATA_WIDTH-bit multiplexer. Its combinational output serves as the per-bit primitive behind mux_4x1 (DATA_WIDTH=1, SELECT_WIDTH=2). It also provides a registered copy of the selection and an out-of-range select flag for pipelined datapath use.

Parameters:
SELECT_WIDTH, 1, width of select; maximum input count is 2**SELECT_WIDTH
NUM_INPUTS, 2**SELECT_WIDTH, number of populated inputs; legal range 2..2**SELECT_WIDTH
DATA_WIDTH, 1, bits per input lane and per output
DEFAULT_VALUE, 0 (DATA_WIDTH bits), value driven when select >= NUM_INPUTS

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  synchronous active-low reset
in  in  NUM_INPUTS*DATA_WIDTH  packed inputs; lane k = in[k*DATA_WIDTH +: DATA_WIDTH]; lane 0 = LSBs
out  out  DATA_WIDTH  combinational selected lane
select  in  SELECT_WIDTH  lane index, unsigned
en  in  1  load enable for the registered outputs
out_q  out  DATA_WIDTH  registered copy of out
sel_err  out  1  combinational: select >= NUM_INPUTS
sel_err_q  out  1  registered copy of sel_err

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Combinational output:
  - out = lane[select] when select < NUM_INPUTS; otherwise out = DEFAULT_VALUE.
  - Zero latency; out follows any change on in or select in the same delta, independent of clk, rst_n and en.
- Select error flag:
  - sel_err = 1 when select >= NUM_INPUTS, else 0.
  - Always 0 when NUM_INPUTS == 2**SELECT_WIDTH.
- Registered path, at each rising clk edge:
  - rst_n == 0: out_q <= 0 and sel_err_q <= 0, regardless of en.
  - rst_n == 1 and en == 1: out_q <= out and sel_err_q <= sel_err.
  - rst_n == 1 and en == 0: out_q and sel_err_q hold.
- Reset values: out_q = 0, sel_err_q = 0. out and sel_err are never reset.
- Latency: out_q lags the sampled out by exactly one clock.
- Reset mid-operation: the registered outputs clear on the next edge with rst_n low. The combinational path is unaffected.
- Simultaneous in/select change with the clock edge: the register captures the pre-edge combinational value. No glitch filtering.
- X on select: out may be X. No X-masking is required.
- Elaboration-time checks: NUM_INPUTS > 2**SELECT_WIDTH, or NUM_INPUTS < 2, is a fatal elaboration error.
- Implementation:
  - Lane selection uses a one-hot decode of select, followed by an AND-OR reduction across lanes per bit.
  - The design must not rely on array indexing with out-of-range values.

Decomposition:
- Shared package mux_pkg holds:
  - a function clog2-safe max-inputs helper (2**SELECT_WIDTH);
  - the default DEFAULT_VALUE constant.
- One sub-module, nbit_onehot_decode:
  - Parameters SELECT_WIDTH and NUM_INPUTS.
  - Outputs a NUM_INPUTS-bit one-hot vector plus a sel_err bit.
  - nbit_mux_core instantiates it once.

Test Plan:
- DATA_WIDTH=32, SELECT_WIDTH=2; lanes AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD.
  - Sweep select 0..3 -> out = AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD.
  - sel_err = 0 throughout.
- Same config, select=1: change lane2 to 12345678 -> out stays BBBBBBBB. Then select=2 -> out = 12345678 in the same time step.
- NUM_INPUTS=3, SELECT_WIDTH=2, DEFAULT_VALUE=FFFFFFFF, select=3 -> out = FFFFFFFF, sel_err = 1. After one edge with en=1 -> out_q = FFFFFFFF, sel_err_q = 1.
- Registered path, select=3, lane3 = 87654321:
  - en=1 -> out_q = 87654321 one cycle later.
  - Drop en, change lane3 to 11111111 -> out = 11111111, out_q holds 87654321.
- Reset with en=1 and out_q = 87654321: rst_n=0 for one edge -> out_q = 0, sel_err_q = 0 on that edge; out still combinationally valid. rst_n=1 plus one edge -> out_q reloads.
- DATA_WIDTH=1, SELECT_WIDTH=2 (mux_4x1 bit-slice), exhaustive: all 16 in patterns x 4 selects -> out == in[select] for all 64 cases.
